// File: rtl/led_pkg.sv
// Shared constants for the LED sequencer: mode encodings, bounce direction
// encodings and the speed index limit, plus a small wrap-around increment.
package led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  // Increment a 2-bit index, returning to zero after max_val.
  function automatic logic [1:0] wrap_inc(input logic [1:0] val,
                                          input logic [1:0] max_val);
    return (val == max_val) ? 2'd0 : val + 2'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, already-synchronous button level.
// History resets to 1 so a button held through reset reads as "already
// pressed" and must be released before it can register a new press.
module btn_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  logic btn_q;

  // Remember last cycle's button level.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block ordering.
    if (i_reset) btn_q <= 1'b1;
    else         btn_q <= i_btn;
  end

  assign o_press = i_btn & ~btn_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: a free-running prescaler produces step ticks whose period is
// 2^(WIDTH-speed) cycles; on each tick the LED register advances according to
// the current mode. Button presses cycle mode/speed and restart the prescaler.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int NLEDS = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_btn_mode,
  input  logic             i_btn_speed,
  output logic [NLEDS-1:0] o_led,
  output logic [1:0]       o_mode,
  output logic [1:0]       o_speed,
  output logic             o_step
);

  localparam logic [NLEDS-1:0] LED_ONE = NLEDS'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       speed_q, speed_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;

  logic             mode_press;
  logic             speed_press;
  logic [WIDTH-1:0] tick_mask;
  logic             tick;

  btn_edge u_mode_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_mode),
    .o_press (mode_press)
  );

  btn_edge u_speed_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_speed),
    .o_press (speed_press)
  );

  // Tick when the low (WIDTH - speed) prescaler bits are all ones.
  assign tick_mask = {WIDTH{1'b1}} >> speed_q;
  assign tick      = ((cnt_q & tick_mask) == tick_mask);

  // Next-state: presses take priority over (and discard) a coincident tick.
  always_comb begin
    // NOTE: every target gets a default first, so no path can leave one
    // unassigned and infer a latch.
    cnt_d   = cnt_q + WIDTH'(1);
    led_d   = led_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    step_d  = 1'b0;

    if (mode_press || speed_press) begin
      cnt_d = '0;
      if (speed_press) speed_d = wrap_inc(speed_q, SPEED_MAX);
      if (mode_press) begin
        mode_d = wrap_inc(mode_q, MODE_BLINK);
        led_d  = (mode_d == MODE_BLINK) ? '1 : LED_ONE;
        dir_d  = DIR_LEFT;
      end
    end else if (tick) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_ROT_L: led_d = {led_q[NLEDS-2:0], led_q[NLEDS-1]};
        MODE_ROT_R: led_d = {led_q[0], led_q[NLEDS-1:1]};
        MODE_BOUNCE: begin
          // At an end facing outward: reverse and move inward on this tick.
          if (dir_q == DIR_LEFT) begin
            if (led_q[NLEDS-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default: led_d = ~led_q;
      endcase
    end
  end

  // State registers; synchronous reset dominates everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      led_q   <= LED_ONE;
      mode_q  <= MODE_ROT_L;
      speed_q <= 2'd0;
      dir_q   <= DIR_LEFT;
      step_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

  assign o_led   = led_q;
  assign o_mode  = mode_q;
  assign o_speed = speed_q;
  assign o_step  = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with WIDTH=4 (base period 16), NLEDS=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_speed = 1'b0;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       step;

  int vectors = 0;
  int miscompares = 0;

  led_seq_ctrl #(.WIDTH(4), .NLEDS(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_btn_mode  (btn_mode),
    .i_btn_speed (btn_speed),
    .o_led       (led),
    .o_mode      (mode),
    .o_speed     (speed),
    .o_step      (step)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle at the following falling edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle button pulse; returns at the falling edge after the press edge.
  task automatic press(input logic m, input logic s);
    btn_mode  = m;
    btn_speed = s;
    cycles(1);
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
  endtask

  // Expect no change for (period-1) edges, then one step to next_led.
  task automatic expect_step(input string tag, input int period,
                             input logic [3:0] cur_led, input logic [3:0] next_led);
    cycles(period - 1);
    check({tag, "_hold_led"}, 8'(led), 8'(cur_led));
    check({tag, "_hold_step"}, 8'(step), 8'd0);
    cycles(1);
    check({tag, "_led"}, 8'(led), 8'(next_led));
    check({tag, "_step"}, 8'(step), 8'd1);
  endtask

  initial begin
    logic [3:0] rot_seq [4];
    logic [3:0] bnc_seq [7];
    logic [3:0] prev;
    rot_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bnc_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // 1. Reset, free-running rotate left at period 16.
    @(negedge clk);
    cycles(2);
    rst = 1'b0;
    check("rst_led", 8'(led), 8'h1);
    check("rst_mode", 8'(mode), 8'd0);
    check("rst_speed", 8'(speed), 8'd0);
    check("rst_step", 8'(step), 8'd0);
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      expect_step("rotl", 16, prev, rot_seq[i]);
      prev = rot_seq[i];
    end
    cycles(1);
    check("rotl_step_pulse_end", 8'(step), 8'd0);
    cycles(14);

    // 2. Speed presses: period 8, then wrap back to speed 0 / period 16.
    press(1'b0, 1'b1);
    check("spd1_speed", 8'(speed), 8'd1);
    check("spd1_led", 8'(led), 8'h1);
    check("spd1_step", 8'(step), 8'd0);
    expect_step("spd1_a", 8, 4'b0001, 4'b0010);
    expect_step("spd1_b", 8, 4'b0010, 4'b0100);
    cycles(1);
    press(1'b0, 1'b1);
    check("spd2_speed", 8'(speed), 8'd2);
    cycles(1);
    press(1'b0, 1'b1);
    check("spd3_speed", 8'(speed), 8'd3);
    cycles(1);
    press(1'b0, 1'b1);
    check("spd_wrap_speed", 8'(speed), 8'd0);
    check("spd_wrap_mode", 8'(mode), 8'd0);
    expect_step("spd0", 16, 4'b0100, 4'b1000);

    // 3. Two mode presses into BOUNCE.
    press(1'b1, 1'b0);
    check("mode1_mode", 8'(mode), 8'd1);
    check("mode1_led", 8'(led), 8'h1);
    cycles(1);
    press(1'b1, 1'b0);
    check("mode2_mode", 8'(mode), 8'd2);
    check("mode2_led", 8'(led), 8'h1);
    check("mode2_step", 8'(step), 8'd0);
    prev = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      expect_step("bounce", 16, prev, bnc_seq[i]);
      prev = bnc_seq[i];
    end

    // 4. BLINK, then wrap back to ROT_L.
    press(1'b1, 1'b0);
    check("blink_mode", 8'(mode), 8'd3);
    check("blink_led", 8'(led), 8'hf);
    expect_step("blink_a", 16, 4'b1111, 4'b0000);
    expect_step("blink_b", 16, 4'b0000, 4'b1111);
    press(1'b1, 1'b0);
    check("wrap_mode", 8'(mode), 8'd0);
    check("wrap_led", 8'(led), 8'h1);

    // 5a. Mode press exactly on the tick cycle: tick discarded.
    cycles(15);
    check("tickpress_pre_led", 8'(led), 8'h1);
    press(1'b1, 1'b0);
    check("tickpress_mode", 8'(mode), 8'd1);
    check("tickpress_led", 8'(led), 8'h1);
    check("tickpress_step", 8'(step), 8'd0);
    expect_step("tickpress_rotr", 16, 4'b0001, 4'b1000);

    // 5b. Mode button held through reset: no press until re-pressed.
    btn_mode = 1'b1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("held_rst_mode", 8'(mode), 8'd0);
    cycles(3);
    check("held_mode", 8'(mode), 8'd0);
    btn_mode = 1'b0;
    cycles(1);
    check("released_mode", 8'(mode), 8'd0);
    press(1'b1, 1'b0);
    check("repress_mode", 8'(mode), 8'd1);

    // 6. Reset mid-BOUNCE (moving right, 0100) at speed 2, on a tick cycle.
    cycles(1);
    press(1'b1, 1'b0);
    check("s6_mode", 8'(mode), 8'd2);
    cycles(1);
    press(1'b0, 1'b1);
    cycles(1);
    press(1'b0, 1'b1);
    check("s6_speed", 8'(speed), 8'd2);
    check("s6_led0", 8'(led), 8'h1);
    cycles(16);
    check("s6_led_right", 8'(led), 8'h4);
    cycles(3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("s6_rst_led", 8'(led), 8'h1);
    check("s6_rst_mode", 8'(mode), 8'd0);
    check("s6_rst_speed", 8'(speed), 8'd0);
    check("s6_rst_step", 8'(step), 8'd0);
    expect_step("s6_after", 16, 4'b0001, 4'b0010);

    // Simultaneous mode and speed press.
    press(1'b1, 1'b1);
    check("both_mode", 8'(mode), 8'd1);
    check("both_speed", 8'(speed), 8'd1);
    check("both_led", 8'(led), 8'h1);
    check("both_step", 8'(step), 8'd0);
    expect_step("both_rotr", 8, 4'b0001, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
